// File: rtl/stream_pkg.sv
// Shared stream definitions: FSM state encoding, index-width helper, default widths.
package stream_pkg;

    localparam int unsigned DEFAULT_PAYLOAD_BITS = 32;
    localparam int unsigned DEFAULT_OUT_BITS     = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Index width for a count of v items; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/stream_slice_sel.sv
// Combinational slice mux: picks one SLICE_BITS-wide slice of a word by index,
// counting from the bottom (MSB_FIRST=0) or from the top (MSB_FIRST=1).
module stream_slice_sel #(
    parameter int unsigned WORD_BITS  = 32,
    parameter int unsigned SLICE_BITS = 8,
    parameter int unsigned IDX_BITS   = 2,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic [WORD_BITS-1:0]  word_i,
    input  logic [IDX_BITS-1:0]   idx_i,
    output logic [SLICE_BITS-1:0] slice_o
);

    localparam int unsigned RATIO = WORD_BITS / SLICE_BITS;

    // Select the slice whose position matches idx_i; out-of-range indices give zero.
    always_comb begin
        slice_o = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (idx_i == IDX_BITS'(i)) begin
                slice_o = word_i[(MSB_FIRST ? (RATIO - 1 - i) : i) * SLICE_BITS +: SLICE_BITS];
            end
        end
    end

endmodule

// File: rtl/stream_serializer.sv
// Width down-converter: accepts PAYLOAD_BITS words on a val/ready stream and emits
// PAYLOAD_BITS/OUT_BITS slices, one per output beat, with no bubble between words.
// Optional feature: define STREAM_SER_CNT_EN to add the 16-bit slice_cnt debug counter port.
module stream_serializer
    import stream_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int unsigned OUT_BITS     = DEFAULT_OUT_BITS,
    parameter bit          MSB_FIRST    = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    val_in,
    output logic                    ready_upward,
    output logic [OUT_BITS-1:0]     dout,
    output logic                    val_out,
    input  logic                    ready_downward
`ifdef STREAM_SER_CNT_EN
    ,
    output logic [15:0]             slice_cnt
`endif
);

    localparam int unsigned RATIO = PAYLOAD_BITS / OUT_BITS;
    localparam int unsigned IDX_W = clog2_min1(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if ((PAYLOAD_BITS % OUT_BITS) != 0 || RATIO < 2) begin : g_param_err
        $error("stream_serializer: PAYLOAD_BITS must be a multiple of OUT_BITS with ratio >= 2");
    end

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] word_q, word_d;
    logic [OUT_BITS-1:0]     slice_w;

    stream_slice_sel #(
        .WORD_BITS  (PAYLOAD_BITS),
        .SLICE_BITS (OUT_BITS),
        .IDX_BITS   (IDX_W),
        .MSB_FIRST  (MSB_FIRST)
    ) u_slice_sel (
        .word_i  (word_q),
        .idx_i   (idx_q),
        .slice_o (slice_w)
    );

    // State, index and word registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    // Next-state and handshake logic; the last slice's output beat may reload the next word.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        val_out      = 1'b0;
        ready_upward = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_upward = 1'b1;
                if (val_in) begin
                    word_d  = din;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                val_out      = 1'b1;
                ready_upward = (idx_q == LAST_IDX) && ready_downward;
                if (ready_downward) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (val_in) begin
                        word_d = din;
                        idx_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dout = (state_q == ST_SEND) ? slice_w : '0;

`ifdef STREAM_SER_CNT_EN
    logic [15:0] cnt_q;

    // Free-running count of output beats, wrapping at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (val_out && ready_downward) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign slice_cnt = cnt_q;
`endif

endmodule
